// File: rtl/parity_frame_tx.sv
// parity_frame_tx
//   Serial frame transmitter. Accepts a 7-bit word over valid/ready, computes
//   its even-parity bit and shifts out one 10-bit frame on tx_serial:
//   start(0), 7 data bits LSB first, parity, stop(1). Each bit is held for
//   CLKS_PER_BIT clocks.
//
//   Optional build macro: DAVIO_CROSSCHECK_EN
//     Defined   - a second parity is built by positive-Davio expansion and
//                 compared with the XOR-reduction parity on every accept edge.
//                 A mismatch sets the sticky parity_err flag.
//     Undefined - no cross-check logic; parity_err is tied low.
//
//   Ports
//     clk         rising-edge clock
//     rst_n       asynchronous active-low reset (aborts any frame in flight)
//     din         data word, sampled only on the accept edge
//     din_valid   upstream has a word on din
//     din_ready   block can accept a word this cycle
//     tx_serial   serial line, idles high
//     tx_busy     frame in flight
//     frame_done  one-cycle pulse after the stop bit completes
//     parity_err  sticky cross-check failure flag
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              frame_done,
  output logic              parity_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  generate
    if (DATA_W != 7) begin : g_bad_width
      $error("parity_frame_tx: DATA_W must be 7");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("parity_frame_tx: CLKS_PER_BIT must be 2..65535");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     baud_cnt, baud_cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              done_d;
  logic              tx_d;
  logic              accept;
  logic              bit_last;
  logic              par_xor;

  assign par_xor  = ^din;
  assign accept   = din_valid && din_ready;
  assign bit_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  // Next-state logic. Outputs are decoded from the *next* state so that
  // every output leaves a flop and lines up with the state it describes.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    data_d     = data_q;
    par_d      = par_q;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          data_d     = din;
          par_d      = par_xor;
          baud_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_last) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          baud_cnt_d = '0;
          if (bit_idx == 3'd6) state_d = PARITY;
          else                 bit_idx_d = bit_idx + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt + CW'(1);
        end
      end
      PARITY: begin
        if (bit_last) begin
          baud_cnt_d = '0;
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_last) begin
          baud_cnt_d = '0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_idx_d];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      data_q     <= '0;
      par_q      <= 1'b0;
      tx_serial  <= 1'b1;
      tx_busy    <= 1'b0;
      din_ready  <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      baud_cnt   <= baud_cnt_d;
      bit_idx    <= bit_idx_d;
      data_q     <= data_d;
      par_q      <= par_d;
      tx_serial  <= tx_d;
      tx_busy    <= (state_d != IDLE);
      din_ready  <= (state_d == IDLE);
      frame_done <= done_d;
    end
  end

`ifdef DAVIO_CROSSCHECK_EN
  // Positive-Davio parity: walking the bits, acc is the parity of the bits
  // already absorbed. Expanding f = x_i ^ acc about x_i gives cofactors
  // f0 = acc, f1 = ~acc, so f = f0 ^ x_i & (f0 ^ f1).
  function automatic logic davio_parity(input logic [DATA_W-1:0] x);
    logic acc, f0, f1;
    acc = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      f0  = acc;
      f1  = ~acc;
      acc = f0 ^ (x[i] & (f0 ^ f1));
    end
    return acc;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   parity_err <= 1'b0;
    else if (accept && (davio_parity(din) != par_xor)) parity_err <= 1'b1;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] din = 7'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, tx_serial, tx_busy, frame_done, parity_err;

  int tests = 0;
  int fails = 0;

  parity_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .tx_serial(tx_serial), .tx_busy(tx_busy),
    .frame_done(frame_done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: 'since' = cycles since the accept edge (cycle 1 = first start-bit
  // cycle, 41 = frame_done cycle), -1 when idle. mbits holds the frame.
  int         since = -1;
  logic [9:0] mbits = 10'h3FF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      since = -1;
    end else if (din_valid && (since == -1 || since == 10*CPB+1)) begin
      mbits[0] = 1'b0;
      for (int i = 0; i < 7; i++) mbits[i+1] = din[i];
      mbits[8] = (($countones(din) % 2) == 1);
      mbits[9] = 1'b1;
      since = 1;
    end else if (since >= 1) begin
      since = (since == 10*CPB+1) ? -1 : since + 1;
    end
  end

  always @(negedge clk) begin
    logic busy_e;
    busy_e = (since >= 1 && since <= 10*CPB);
    chk("m_tx",    tx_serial,  busy_e ? mbits[(since-1)/CPB] : 1'b1);
    chk("m_busy",  tx_busy,    busy_e);
    chk("m_ready", din_ready,  !busy_e);
    chk("m_done",  frame_done, since == 10*CPB+1);
    chk("m_perr",  parity_err, 1'b0);
  end

  // Present w for one cycle; returns at the negedge of cycle 1.
  // din is then scrambled to show the latched word is immune.
  task automatic start_word(input logic [6:0] w);
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    din = ~w;
  endtask

  initial begin
    logic [9:0] exp55;
    int pulses;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", din_ready, 1'b1);
    chk("rst_tx",    tx_serial, 1'b1);
    chk("rst_busy",  tx_busy,   1'b0);
    chk("rst_done",  frame_done, 1'b0);
    chk("rst_perr",  parity_err, 1'b0);

    // Single frame 7'h55: frame bit i is exp55[i]
    exp55 = 10'b1_0_1010101_0;
    start_word(7'h55);
    for (int k = 1; k <= 41; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 40) chk("f55_tx", tx_serial, exp55[(k-1)/4]);
      else begin
        chk("f55_done",  frame_done, 1'b1);
        chk("f55_ready", din_ready,  1'b1);
      end
    end

    // Odd-weight words: parity bit high in cycles 33..36
    start_word(7'h01);
    for (int k = 1; k <= 41; k++) begin
      if (k > 1) @(negedge clk);
      if (k >= 33 && k <= 36) chk("f01_par", tx_serial, 1'b1);
    end
    start_word(7'h7F);
    for (int k = 1; k <= 41; k++) begin
      if (k > 1) @(negedge clk);
      if (k >= 33 && k <= 36) chk("f7f_par", tx_serial, 1'b1);
    end

    // Back-to-back with din_valid held high
    @(negedge clk);
    din = 7'h12;
    din_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      if (k == 1)  din = 7'h6C;
      if (k == 20) chk("b2b_ready_low", din_ready, 1'b0);
      if (k == 41) begin
        chk("b2b_done41",  frame_done, 1'b1);
        chk("b2b_tx41",    tx_serial,  1'b1);
      end
      if (k == 42) begin
        chk("b2b_start42", tx_serial, 1'b0);
        chk("b2b_busy42",  tx_busy,   1'b1);
        din_valid = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
    chk("b2b_done2", frame_done, 1'b1);

    // Reset mid-frame during DATA (cycle 15 carries d2 of 7'h0A = 0)
    start_word(7'h0A);
    repeat (14) @(negedge clk);
    chk("mid_tx_before", tx_serial, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_tx_async",   tx_serial, 1'b1);
    chk("mid_busy_async", tx_busy,   1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (45) begin
      @(negedge clk);
      pulses += int'(frame_done);
    end
    chk("mid_no_done", pulses, 0);
    start_word(7'h33);
    repeat (40) @(negedge clk);
    chk("mid_clean_done", frame_done, 1'b1);

    // Exhaustive sweep; the model checks each parity bit every cycle
    for (int w = 0; w < 128; w++) begin
      start_word(7'(w));
      repeat (40) @(negedge clk);
    end
    chk("sweep_perr", parity_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
